frame_draw_scheduler: RTL and testbench
=======================================

Name: frame_draw_scheduler

Overview:
Owns the single VGA framebuffer write port (x, y, colour, plot).
On each frame tick it sequences a full-screen background clear sweep, then arbitrates per-pixel writes from the snake-draw and food-draw requesters until the next tick.
It sits between the game logic draw units and the VGA adapter, and replaces ad-hoc clear-screen reset gating with one scheduled owner of the port.

Parameters:
SCREEN_W, 160, pixels per row; x range 0..SCREEN_W-1
SCREEN_H, 120, rows; y range 0..SCREEN_H-1
COLOUR_W, 3, colour width in bits
BG_COLOUR, 3'b000, colour written during the clear sweep

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse marking the start of a frame
clear_en  in  1  sampled with frame_tick; 1 = run the clear sweep, 0 = go straight to SERVE
snake_req  in  1  snake requester has a pixel pending; held until acknowledged
snake_x  in  8  snake pixel x
snake_y  in  7  snake pixel y
snake_colour  in  COLOUR_W  snake pixel colour
snake_ack  out  1  one-cycle pulse: snake pixel accepted
food_req  in  1  food requester has a pixel pending
food_x  in  8  food pixel x
food_y  in  7  food pixel y
food_colour  in  COLOUR_W  food pixel colour
food_ack  out  1  one-cycle pulse: food pixel accepted
vga_x  out  8  framebuffer write x (registered)
vga_y  out  7  framebuffer write y (registered)
vga_colour  out  COLOUR_W  framebuffer write colour (registered)
vga_plot  out  1  framebuffer write enable (registered)
busy  out  1  high while in CLEAR
clear_done  out  1  one-cycle pulse after the last clear pixel is issued
overrun  out  1  sticky: a frame_tick arrived during CLEAR

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous and active-low, reset_n.
- Reset state: state=IDLE.
- Reset values: all outputs 0; sweep counters 0; round-robin pointer = snake.
- States: IDLE, CLEAR, SERVE.
- IDLE:
  - frame_tick & clear_en -> CLEAR.
  - frame_tick & !clear_en -> SERVE.
  - Otherwise stay; no plots, no acks.
- CLEAR:
  - Every cycle, issue one plot at (cx, cy) with BG_COLOUR.
  - cx increments first; on cx=SCREEN_W-1, cx wraps to 0 and cy increments.
  - The pixel at (SCREEN_W-1, SCREEN_H-1) is the last one. After it: -> SERVE, counters return to 0, clear_done pulses in the cycle that last plot is visible on vga_plot.
  - Exactly SCREEN_W*SCREEN_H plots, no gaps, no duplicates. A 160x120 screen takes 19200 cycles.
  - No acks are issued; requests stay pending.
  - A frame_tick during CLEAR is ignored (the sweep is not restarted) and sets overrun.
- SERVE:
  - Eligible requester: req=1 and its ack was not high in the previous cycle. This prevents double grant of a held request.
  - One eligible requester: grant it.
  - Both eligible: grant the one named by the round-robin pointer. After any grant, the pointer moves to the other requester.
  - On a grant in cycle N: in cycle N+1, vga_x/y/colour hold the granted requester's data sampled in cycle N, vga_plot=1 and that requester's ack=1. Latency is one cycle.
  - Requester rule: on seeing ack, drop req or present the next pixel. The next pixel is granted no earlier than the cycle after ack.
  - No eligible request: vga_plot=0.
  - frame_tick in SERVE: behaves as in IDLE. The next state is CLEAR or SERVE per clear_en. A grant in the same cycle is discarded (no plot, no ack).
- Coordinate checks: x >= SCREEN_W or y >= SCREEN_H on a granted request is still acked, but vga_plot stays 0 (pixel dropped silently).
- Port ownership: vga_plot is never driven by two sources. Exactly one of {clear sweep, snake, food, none} owns the port each cycle.
- overrun: cleared only by reset.
- Reset mid-sweep: returns to IDLE immediately; the sweep does not resume. The next frame_tick restarts it from (0,0).

Decomposition:
- Shared package draw_pkg holds:
  - state enum (IDLE/CLEAR/SERVE)
  - SCREEN_W/SCREEN_H defaults
  - COLOUR_W and colour constants (BLACK etc.)
  - the x/y width constants (8/7)
- One sub-module: screen_sweep_counter.
  - Inputs: enable and clear.
  - Outputs: cx, cy, last.
  - Parameterised by SCREEN_W/SCREEN_H.
  - It replaces the current drawBlack sweep logic and fixes its off-by-one wrap.
- The arbiter and FSM stay in frame_draw_scheduler.

Test Plan:
- Clear sweep, SCREEN_W=4, SCREEN_H=3: frame_tick with clear_en=1 -> 12 consecutive plots (0,0),(1,0)..(3,2), all colour 0; busy high for exactly 12 cycles; clear_done pulses once with the (3,2) plot; then SERVE.
- Single requester: in SERVE, snake_req=1 at (10,20), colour 3'b100 -> next cycle vga_plot=1, vga_x=10, vga_y=20, colour 3'b100, snake_ack=1; req held one more cycle -> no second plot that cycle.
- Contention: snake_req and food_req both held continuously with distinct data -> plots alternate snake, food, snake, food; each ack aligned with its plot; no gap cycles beyond the required one-cycle ack spacing per requester.
- Requests during clear: snake_req raised mid-sweep -> no snake_ack until after clear_done; first SERVE cycle grants it.
- Overrun: a second frame_tick at sweep pixel 5 -> sweep completes all 12 pixels unchanged; overrun=1 and stays 1.
- Reset and bounds: reset_n low at sweep pixel 7 -> all outputs 0 asynchronously; next frame_tick restarts at (0,0). Separately, food request at x=200 -> food_ack=1, vga_plot=0.

Source files
------------

// File: rtl/draw_pkg.sv
// Shared types and constants for the framebuffer draw path: screen geometry,
// coordinate widths, colour palette and the scheduler state encoding.
package draw_pkg;

  localparam int X_W              = 8;
  localparam int Y_W              = 7;
  localparam int COLOUR_W         = 3;
  localparam int SCREEN_W_DEFAULT = 160;
  localparam int SCREEN_H_DEFAULT = 120;

  localparam logic [COLOUR_W-1:0] BLACK   = 3'b000;
  localparam logic [COLOUR_W-1:0] BLUE    = 3'b001;
  localparam logic [COLOUR_W-1:0] GREEN   = 3'b010;
  localparam logic [COLOUR_W-1:0] CYAN    = 3'b011;
  localparam logic [COLOUR_W-1:0] RED     = 3'b100;
  localparam logic [COLOUR_W-1:0] MAGENTA = 3'b101;
  localparam logic [COLOUR_W-1:0] YELLOW  = 3'b110;
  localparam logic [COLOUR_W-1:0] WHITE   = 3'b111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CLEAR = 2'd1,
    SERVE = 2'd2
  } draw_state_e;

  typedef enum logic {
    SRC_SNAKE = 1'b0,
    SRC_FOOD  = 1'b1
  } draw_src_e;

  function automatic logic on_screen(input logic [X_W-1:0] x, input logic [Y_W-1:0] y,
                                     input int w, input int h);
    return (int'(x) < w) && (int'(y) < h);
  endfunction

endpackage

// File: rtl/screen_sweep_counter.sv
// Raster-order pixel counter for the background clear: x runs fastest, y
// advances when x wraps, last flags the bottom-right pixel.
module screen_sweep_counter
  import draw_pkg::*;
#(
  parameter int SCREEN_W = SCREEN_W_DEFAULT,
  parameter int SCREEN_H = SCREEN_H_DEFAULT
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           enable_i,
  input  logic           clear_i,
  output logic [X_W-1:0] cx_o,
  output logic [Y_W-1:0] cy_o,
  output logic           last_o
);

  localparam logic [X_W-1:0] X_MAX = X_W'(SCREEN_W - 1);
  localparam logic [Y_W-1:0] Y_MAX = Y_W'(SCREEN_H - 1);

  logic [X_W-1:0] cx_q, cx_d;
  logic [Y_W-1:0] cy_q, cy_d;
  logic           x_last;

  // Wrap on the last column itself, so the row advances right after X_MAX is drawn.
  assign x_last = (cx_q == X_MAX);
  assign last_o = x_last && (cy_q == Y_MAX);

  always_comb begin
    // NOTE: defaults first so every path assigns cx_d/cy_d and no latch is inferred.
    cx_d = cx_q;
    cy_d = cy_q;
    if (clear_i) begin
      cx_d = '0;
      cy_d = '0;
    end else if (enable_i) begin
      if (x_last) begin
        cx_d = '0;
        cy_d = last_o ? '0 : cy_q + 1'b1;
      end else begin
        cx_d = cx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: state updates use non-blocking assignments so all flops see pre-edge values.
    if (!reset_n) begin
      cx_q <= '0;
      cy_q <= '0;
    end else begin
      cx_q <= cx_d;
      cy_q <= cy_d;
    end
  end

  assign cx_o = cx_q;
  assign cy_o = cy_q;

endmodule

// File: rtl/frame_draw_scheduler.sv
// Single owner of the framebuffer write port: per frame, an optional clear
// sweep followed by round-robin service of the snake and food draw requesters.
module frame_draw_scheduler
  import draw_pkg::*;
#(
  parameter int                  SCREEN_W  = SCREEN_W_DEFAULT,
  parameter int                  SCREEN_H  = SCREEN_H_DEFAULT,
  parameter int                  COLOUR_W  = draw_pkg::COLOUR_W,
  parameter logic [COLOUR_W-1:0] BG_COLOUR = COLOUR_W'(BLACK)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                frame_tick,
  input  logic                clear_en,
  input  logic                snake_req,
  input  logic [X_W-1:0]      snake_x,
  input  logic [Y_W-1:0]      snake_y,
  input  logic [COLOUR_W-1:0] snake_colour,
  output logic                snake_ack,
  input  logic                food_req,
  input  logic [X_W-1:0]      food_x,
  input  logic [Y_W-1:0]      food_y,
  input  logic [COLOUR_W-1:0] food_colour,
  output logic                food_ack,
  output logic [X_W-1:0]      vga_x,
  output logic [Y_W-1:0]      vga_y,
  output logic [COLOUR_W-1:0] vga_colour,
  output logic                vga_plot,
  output logic                busy,
  output logic                clear_done,
  output logic                overrun
);

  draw_state_e         state_q, state_d;
  draw_src_e           ptr_q, ptr_d;
  logic [X_W-1:0]      vga_x_q, vga_x_d;
  logic [Y_W-1:0]      vga_y_q, vga_y_d;
  logic [COLOUR_W-1:0] vga_colour_q, vga_colour_d;
  logic                vga_plot_q, vga_plot_d;
  logic                snake_ack_q, snake_ack_d;
  logic                food_ack_q, food_ack_d;
  logic                busy_q, busy_d;
  logic                clear_done_q, clear_done_d;
  logic                overrun_q, overrun_d;

  logic [X_W-1:0] cx;
  logic [Y_W-1:0] cy;
  logic           sweep_last;
  logic           in_clear;

  assign in_clear = (state_q == CLEAR);

  screen_sweep_counter #(
    .SCREEN_W (SCREEN_W),
    .SCREEN_H (SCREEN_H)
  ) u_sweep (
    .clk      (clk),
    .reset_n  (reset_n),
    .enable_i (in_clear),
    .clear_i  (!in_clear),
    .cx_o     (cx),
    .cy_o     (cy),
    .last_o   (sweep_last)
  );

  // A requester acked this cycle is still showing the pixel just taken; skip it once.
  logic snake_elig, food_elig, grant_snake, grant_food;
  assign snake_elig  = snake_req && !snake_ack_q;
  assign food_elig   = food_req && !food_ack_q;
  assign grant_snake = snake_elig && (!food_elig || ptr_q == SRC_SNAKE);
  assign grant_food  = food_elig && !grant_snake;

  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    vga_x_d      = '0;
    vga_y_d      = '0;
    vga_colour_d = '0;
    vga_plot_d   = 1'b0;
    snake_ack_d  = 1'b0;
    food_ack_d   = 1'b0;
    clear_done_d = 1'b0;
    overrun_d    = overrun_q;

    case (state_q)
      IDLE: begin
        if (frame_tick) begin
          if (clear_en) state_d = CLEAR;
          else          state_d = SERVE;
        end
      end

      CLEAR: begin
        vga_x_d      = cx;
        vga_y_d      = cy;
        vga_colour_d = BG_COLOUR;
        vga_plot_d   = 1'b1;
        if (frame_tick) overrun_d = 1'b1;
        if (sweep_last) begin
          state_d      = SERVE;
          clear_done_d = 1'b1;
        end
      end

      SERVE: begin
        if (frame_tick) begin
          if (clear_en) state_d = CLEAR;
          else          state_d = SERVE;
        end else if (grant_snake) begin
          snake_ack_d  = 1'b1;
          ptr_d        = SRC_FOOD;
          vga_x_d      = snake_x;
          vga_y_d      = snake_y;
          vga_colour_d = snake_colour;
          vga_plot_d   = on_screen(snake_x, snake_y, SCREEN_W, SCREEN_H);
        end else if (grant_food) begin
          food_ack_d   = 1'b1;
          ptr_d        = SRC_SNAKE;
          vga_x_d      = food_x;
          vga_y_d      = food_y;
          vga_colour_d = food_colour;
          vga_plot_d   = on_screen(food_x, food_y, SCREEN_W, SCREEN_H);
        end
      end

      default: state_d = IDLE;
    endcase

    busy_d = (state_d == CLEAR);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      ptr_q        <= SRC_SNAKE;
      vga_x_q      <= '0;
      vga_y_q      <= '0;
      vga_colour_q <= '0;
      vga_plot_q   <= 1'b0;
      snake_ack_q  <= 1'b0;
      food_ack_q   <= 1'b0;
      busy_q       <= 1'b0;
      clear_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      vga_x_q      <= vga_x_d;
      vga_y_q      <= vga_y_d;
      vga_colour_q <= vga_colour_d;
      vga_plot_q   <= vga_plot_d;
      snake_ack_q  <= snake_ack_d;
      food_ack_q   <= food_ack_d;
      busy_q       <= busy_d;
      clear_done_q <= clear_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign vga_x      = vga_x_q;
  assign vga_y      = vga_y_q;
  assign vga_colour = vga_colour_q;
  assign vga_plot   = vga_plot_q;
  assign snake_ack  = snake_ack_q;
  assign food_ack   = food_ack_q;
  assign busy       = busy_q;
  assign clear_done = clear_done_q;
  assign overrun    = overrun_q;

endmodule

// File: tb/tb_frame_draw_scheduler.sv
// Bench for frame_draw_scheduler: a 4x3 instance for the clear sweep and a
// 160x120 instance for serving, both checked against a frame-level model.
module tb_frame_draw_scheduler;

  localparam int SW = 4;
  localparam int SH = 3;
  localparam int BW = 160;
  localparam int BH = 120;

  typedef struct packed {
    logic       tick;
    logic       clr;
    logic       sreq;
    logic [7:0] sx;
    logic [6:0] sy;
    logic [2:0] sc;
    logic       freq;
    logic [7:0] fx;
    logic [6:0] fy;
    logic [2:0] fc;
  } drv_t;

  typedef struct packed {
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] c;
    logic       plot;
    logic       sack;
    logic       fack;
    logic       busy;
    logic       done;
    logic       ovr;
  } obs_t;

  typedef enum int {M_IDLE, M_CLEAR, M_SERVE} mode_e;

  typedef struct {
    mode_e mode;
    int    pix;      // raster index of the next clear pixel
    bit    rr_food;  // food wins the next tie
    obs_t  o;
  } mdl_t;

  logic clk = 1'b0;
  logic reset_n;
  drv_t in_s, in_b;
  obs_t out_s, out_b;
  mdl_t ms, mb;
  int   total = 0;
  int   bad   = 0;

  logic [7:0] s_x, b_x;
  logic [6:0] s_y, b_y;
  logic [2:0] s_c, b_c;
  logic s_plot, s_sack, s_fack, s_busy, s_done, s_ovr;
  logic b_plot, b_sack, b_fack, b_busy, b_done, b_ovr;

  always #5 clk = ~clk;

  frame_draw_scheduler #(.SCREEN_W(SW), .SCREEN_H(SH)) u_small (
    .clk(clk), .reset_n(reset_n), .frame_tick(in_s.tick), .clear_en(in_s.clr),
    .snake_req(in_s.sreq), .snake_x(in_s.sx), .snake_y(in_s.sy), .snake_colour(in_s.sc),
    .snake_ack(s_sack),
    .food_req(in_s.freq), .food_x(in_s.fx), .food_y(in_s.fy), .food_colour(in_s.fc),
    .food_ack(s_fack),
    .vga_x(s_x), .vga_y(s_y), .vga_colour(s_c), .vga_plot(s_plot),
    .busy(s_busy), .clear_done(s_done), .overrun(s_ovr)
  );

  frame_draw_scheduler #(.SCREEN_W(BW), .SCREEN_H(BH)) u_big (
    .clk(clk), .reset_n(reset_n), .frame_tick(in_b.tick), .clear_en(in_b.clr),
    .snake_req(in_b.sreq), .snake_x(in_b.sx), .snake_y(in_b.sy), .snake_colour(in_b.sc),
    .snake_ack(b_sack),
    .food_req(in_b.freq), .food_x(in_b.fx), .food_y(in_b.fy), .food_colour(in_b.fc),
    .food_ack(b_fack),
    .vga_x(b_x), .vga_y(b_y), .vga_colour(b_c), .vga_plot(b_plot),
    .busy(b_busy), .clear_done(b_done), .overrun(b_ovr)
  );

  assign out_s = {s_x, s_y, s_c, s_plot, s_sack, s_fack, s_busy, s_done, s_ovr};
  assign out_b = {b_x, b_y, b_c, b_plot, b_sack, b_fack, b_busy, b_done, b_ovr};

  function automatic mdl_t reset_model();
    mdl_t m;
    m.mode    = M_IDLE;
    m.pix     = 0;
    m.rr_food = 1'b0;
    m.o       = '0;
    return m;
  endfunction

  // One clock edge of the scheduler, phrased as frame rules: sweep raster index,
  // one-cycle-late acks, alternating tie winner, off-screen pixels dropped.
  function automatic mdl_t model_step(input mdl_t m, input drv_t d, input int w, input int h);
    mdl_t n;
    bit   s_el, f_el, take_s, take_f;
    n       = m;
    n.o     = '0;
    n.o.ovr = m.o.ovr;
    case (m.mode)
      M_IDLE: begin
        if (d.tick) begin
          n.mode = d.clr ? M_CLEAR : M_SERVE;
          n.pix  = 0;
        end
      end
      M_CLEAR: begin
        n.o.plot = 1'b1;
        n.o.x    = 8'(m.pix % w);
        n.o.y    = 7'(m.pix / w);
        n.o.c    = 3'b000;
        if (d.tick) n.o.ovr = 1'b1;
        if (m.pix == w * h - 1) begin
          n.o.done = 1'b1;
          n.mode   = M_SERVE;
          n.pix    = 0;
        end else begin
          n.pix = m.pix + 1;
        end
      end
      default: begin
        if (d.tick) begin
          n.mode = d.clr ? M_CLEAR : M_SERVE;
        end else begin
          s_el   = d.sreq && !m.o.sack;
          f_el   = d.freq && !m.o.fack;
          take_s = s_el && (!f_el || !m.rr_food);
          take_f = f_el && !take_s;
          if (take_s) begin
            n.o.sack  = 1'b1;
            n.rr_food = 1'b1;
            if (int'(d.sx) < w && int'(d.sy) < h) begin
              n.o.plot = 1'b1; n.o.x = d.sx; n.o.y = d.sy; n.o.c = d.sc;
            end
          end else if (take_f) begin
            n.o.fack  = 1'b1;
            n.rr_food = 1'b0;
            if (int'(d.fx) < w && int'(d.fy) < h) begin
              n.o.plot = 1'b1; n.o.x = d.fx; n.o.y = d.fy; n.o.c = d.fc;
            end
          end
        end
      end
    endcase
    n.o.busy = (n.mode == M_CLEAR);
    return n;
  endfunction

  // Requester: after an ack (or while idle) either go quiet or offer a fresh pixel.
  function automatic drv_t agent(input drv_t d, input mdl_t m, input int xr, input int yr);
    drv_t n;
    n = d;
    if (m.o.sack || !d.sreq) begin
      n.sreq = ($urandom_range(0, 1) == 1);
      n.sx   = 8'($urandom_range(0, xr - 1));
      n.sy   = 7'($urandom_range(0, yr - 1));
      n.sc   = 3'($urandom_range(0, 7));
    end
    if (m.o.fack || !d.freq) begin
      n.freq = ($urandom_range(0, 1) == 1);
      n.fx   = 8'($urandom_range(0, xr - 1));
      n.fy   = 7'($urandom_range(0, yr - 1));
      n.fc   = 3'($urandom_range(0, 7));
    end
    return n;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all(input string pre, input obs_t o, input mdl_t m);
    check({pre, ".plot"},       32'(o.plot), 32'(m.o.plot));
    check({pre, ".snake_ack"},  32'(o.sack), 32'(m.o.sack));
    check({pre, ".food_ack"},   32'(o.fack), 32'(m.o.fack));
    check({pre, ".busy"},       32'(o.busy), 32'(m.o.busy));
    check({pre, ".clear_done"}, 32'(o.done), 32'(m.o.done));
    check({pre, ".overrun"},    32'(o.ovr),  32'(m.o.ovr));
    if (m.o.plot) begin
      check({pre, ".x"},      32'(o.x), 32'(m.o.x));
      check({pre, ".y"},      32'(o.y), 32'(m.o.y));
      check({pre, ".colour"}, 32'(o.c), 32'(m.o.c));
    end
  endtask

  task automatic step();
    @(posedge clk);
    if (reset_n) begin
      ms = model_step(ms, in_s, SW, SH);
      mb = model_step(mb, in_b, BW, BH);
    end else begin
      ms = reset_model();
      mb = reset_model();
    end
    #1;
    compare_all("s", out_s, ms);
    compare_all("b", out_b, mb);
  endtask

  initial begin
    int busy_cnt, plot_cnt, done_cnt, done_at, ack_at;

    reset_n = 1'b0;
    in_s    = '0;
    in_b    = '0;
    ms      = reset_model();
    mb      = reset_model();
    #12;
    compare_all("rst_s", out_s, ms);
    compare_all("rst_b", out_b, mb);
    @(negedge clk);
    reset_n = 1'b1;
    step();
    step();

    // Full clear sweep on the 4x3 screen; the big screen goes straight to SERVE.
    busy_cnt = 0; plot_cnt = 0; done_cnt = 0; done_at = -1;
    in_s.tick = 1'b1; in_s.clr = 1'b1;
    in_b.tick = 1'b1; in_b.clr = 1'b0;
    for (int i = 0; i < 14; i++) begin
      step();
      in_s.tick = 1'b0;
      in_b.tick = 1'b0;
      busy_cnt += int'(out_s.busy);
      plot_cnt += int'(out_s.plot);
      if (out_s.done) begin
        done_cnt++;
        done_at = i;
      end
    end
    check("sweep.plots", plot_cnt, 12);
    check("sweep.busy_cycles", busy_cnt, 12);
    check("sweep.done_pulses", done_cnt, 1);
    check("sweep.done_with_last", done_at, 12);

    // Single requester, held one cycle past its ack.
    in_b.sreq = 1'b1; in_b.sx = 8'd10; in_b.sy = 7'd20; in_b.sc = 3'b100;
    step();
    check("single.plot", 32'(out_b.plot), 1);
    check("single.x", 32'(out_b.x), 10);
    check("single.y", 32'(out_b.y), 20);
    check("single.colour", 32'(out_b.c), 32'b100);
    check("single.ack", 32'(out_b.sack), 1);
    step();
    check("single.held_no_plot", 32'(out_b.plot), 0);
    check("single.held_no_ack", 32'(out_b.sack), 0);
    in_b.sreq = 1'b0;
    step();

    // Contention: snake won last, so food takes the first tie, then they alternate.
    in_b.sreq = 1'b1; in_b.sx = 8'd1;  in_b.sy = 7'd1;  in_b.sc = 3'b001;
    in_b.freq = 1'b1; in_b.fx = 8'd50; in_b.fy = 7'd60; in_b.fc = 3'b110;
    for (int i = 0; i < 8; i++) begin
      step();
      check("cont.plot", 32'(out_b.plot), 1);
      check("cont.food_turn", 32'(out_b.fack), 32'((i % 2) == 0));
      check("cont.snake_turn", 32'(out_b.sack), 32'((i % 2) == 1));
      if (mb.o.sack) in_b.sx = in_b.sx + 8'd1;
      if (mb.o.fack) in_b.fx = in_b.fx + 8'd1;
    end
    in_b.sreq = 1'b0; in_b.freq = 1'b0;
    step();

    // Snake request raised mid-sweep waits for the sweep to finish.
    done_at = -1; ack_at = -1;
    in_s.tick = 1'b1; in_s.clr = 1'b1;
    step();
    in_s.tick = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i == 4) begin
        in_s.sreq = 1'b1; in_s.sx = 8'd2; in_s.sy = 7'd1; in_s.sc = 3'b010;
      end
      step();
      if (out_s.done) done_at = i;
      if (out_s.sack && ack_at < 0) ack_at = i;
      if (ms.o.sack) in_s.sreq = 1'b0;
    end
    check("clrreq.done_at", done_at, 11);
    check("clrreq.ack_at", ack_at, 12);

    // Second frame_tick at sweep pixel 5: sweep runs on, overrun latches.
    plot_cnt = 0;
    check("ovr.before", 32'(out_s.ovr), 0);
    in_s.tick = 1'b1; in_s.clr = 1'b1;
    step();
    in_s.tick = 1'b0;
    for (int i = 0; i < 15; i++) begin
      if (i == 5) in_s.tick = 1'b1;
      step();
      in_s.tick = 1'b0;
      plot_cnt += int'(out_s.plot);
    end
    check("ovr.plots", plot_cnt, 12);
    check("ovr.set", 32'(out_s.ovr), 1);
    step();
    step();
    check("ovr.sticky", 32'(out_s.ovr), 1);

    // Asynchronous reset in the middle of a sweep, then a fresh sweep from (0,0).
    in_s.tick = 1'b1; in_s.clr = 1'b1;
    in_b.tick = 1'b1; in_b.clr = 1'b0;
    step();
    in_s.tick = 1'b0; in_b.tick = 1'b0;
    for (int i = 0; i < 8; i++) step();
    #2;
    reset_n = 1'b0;
    #1;
    ms = reset_model();
    mb = reset_model();
    compare_all("arst_s", out_s, ms);
    compare_all("arst_b", out_b, mb);
    check("arst.x", 32'(out_s.x), 0);
    check("arst.y", 32'(out_s.y), 0);
    step();
    step();
    @(negedge clk);
    reset_n = 1'b1;
    step();
    in_s.tick = 1'b1; in_s.clr = 1'b1;
    in_b.tick = 1'b1; in_b.clr = 1'b0;
    step();
    in_s.tick = 1'b0; in_b.tick = 1'b0;
    step();
    check("restart.plot", 32'(out_s.plot), 1);
    check("restart.x", 32'(out_s.x), 0);
    check("restart.y", 32'(out_s.y), 0);
    check("restart.overrun", 32'(out_s.ovr), 0);
    for (int i = 0; i < 12; i++) step();

    // Off-screen pixels are acked but never plotted.
    in_b.freq = 1'b1; in_b.fx = 8'd200; in_b.fy = 7'd5; in_b.fc = 3'b111;
    step();
    check("bounds_x.ack", 32'(out_b.fack), 1);
    check("bounds_x.plot", 32'(out_b.plot), 0);
    in_b.freq = 1'b0;
    step();
    in_b.freq = 1'b1; in_b.fx = 8'd5; in_b.fy = 7'd125;
    step();
    check("bounds_y.ack", 32'(out_b.fack), 1);
    check("bounds_y.plot", 32'(out_b.plot), 0);
    in_b.freq = 1'b0;
    step();

    // Randomised traffic with occasional frame ticks.
    for (int i = 0; i < 600; i++) begin
      in_s      = agent(in_s, ms, 6, 5);
      in_b      = agent(in_b, mb, 170, 128);
      in_s.tick = ($urandom_range(0, 39) == 0);
      in_s.clr  = ($urandom_range(0, 1) == 1);
      in_b.tick = ($urandom_range(0, 59) == 0);
      in_b.clr  = 1'b0;
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
